// File: rtl/latency_sm.sv
// latency_sm: fixed-latency result tracker for a board evaluation pipeline.
// board_valid starts (or restarts) a LATENCY_COUNT-cycle countdown; when it
// expires eval_valid rises and is held until clear_eval or a newer board.
// Optional feature macro: LATENCY_SM_BUSY_EN adds a registered busy output
// that is high while the countdown is running.
module latency_sm #(
    parameter int unsigned LATENCY_COUNT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic board_valid,
    input  logic clear_eval,
    output logic eval_valid
`ifdef LATENCY_SM_BUSY_EN
    ,
    output logic busy
`endif
);

    localparam int unsigned CW = $clog2(LATENCY_COUNT + 1);
    localparam logic [CW-1:0] RELOAD = CW'(LATENCY_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        VALID = 2'b10
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] next_cnt;
    logic          eval_valid_d;
`ifdef LATENCY_SM_BUSY_EN
    logic          busy_d;
`endif

    // State, counter and registered outputs; reset discards any evaluation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            eval_valid <= 1'b0;
`ifdef LATENCY_SM_BUSY_EN
            busy       <= 1'b0;
`endif
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            eval_valid <= eval_valid_d;
`ifdef LATENCY_SM_BUSY_EN
            busy       <= busy_d;
`endif
        end
    end

    // Next state: a new board always wins and restarts the countdown.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (board_valid) begin
                    next_state = COUNT;
                    next_cnt   = RELOAD;
                end
            end
            COUNT: begin
                if (board_valid) begin
                    next_cnt   = RELOAD;
                end else if (clear_eval) begin
                    next_state = IDLE;
                end else if (cnt == '0) begin
                    next_state = VALID;
                end else begin
                    next_cnt   = cnt - CW'(1);
                end
            end
            VALID: begin
                if (board_valid) begin
                    next_state = COUNT;
                    next_cnt   = RELOAD;
                end else if (clear_eval) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode from next state so the flops mirror the state register.
    always_comb begin
        eval_valid_d = (next_state == VALID);
`ifdef LATENCY_SM_BUSY_EN
        busy_d       = (next_state == COUNT);
`endif
    end

endmodule

// File: tb/tb_latency_sm.sv
// tb_latency_sm: scoreboard bench for latency_sm with three instances
// (LATENCY_COUNT = 11, 1, 4) driven by shared stimulus. Expected outputs come
// from a deadline-based reference model (absolute edge at which the result
// becomes valid) and are queued per edge; a monitor pops and compares.
// Busy checks are included when LATENCY_SM_BUSY_EN is defined.
module tb_latency_sm;

    localparam int NI = 3;
    localparam int LAT [NI] = '{11, 1, 4};

    logic clk = 1'b0;
    logic reset;
    logic board_valid;
    logic clear_eval;
    logic ev11, ev1, ev4;
    logic [NI-1:0] ev_v;
    assign ev_v = {ev4, ev1, ev11};
`ifdef LATENCY_SM_BUSY_EN
    logic bz11, bz1, bz4;
    logic [NI-1:0] bz_v;
    assign bz_v = {bz4, bz1, bz11};
`endif

    always #5 clk = ~clk;

    latency_sm #(.LATENCY_COUNT(11)) u_dut11 (
        .clk(clk), .reset(reset), .board_valid(board_valid),
        .clear_eval(clear_eval), .eval_valid(ev11)
`ifdef LATENCY_SM_BUSY_EN
        , .busy(bz11)
`endif
    );

    latency_sm #(.LATENCY_COUNT(1)) u_dut1 (
        .clk(clk), .reset(reset), .board_valid(board_valid),
        .clear_eval(clear_eval), .eval_valid(ev1)
`ifdef LATENCY_SM_BUSY_EN
        , .busy(bz1)
`endif
    );

    latency_sm #(.LATENCY_COUNT(4)) u_dut4 (
        .clk(clk), .reset(reset), .board_valid(board_valid),
        .clear_eval(clear_eval), .eval_valid(ev4)
`ifdef LATENCY_SM_BUSY_EN
        , .busy(bz4)
`endif
    );

    typedef struct packed {
        logic [NI-1:0] ev;
        logic [NI-1:0] busy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: absolute edge index at which each result becomes valid.
    int   edge_n = 0;
    int   deadline [NI];
    bit   valid_m  [NI];

    task automatic check(input string name, input int idx, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [L=%0d] t=%0t: got %b expected %b", name, LAT[idx], $time, got, exp);
        end
    endtask

    task automatic model_step(input bit bv, input bit clr, input bit rst);
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                deadline[i] = -1;
                valid_m[i]  = 1'b0;
            end else if (bv) begin
                deadline[i] = edge_n + LAT[i];
                valid_m[i]  = 1'b0;
            end else if (clr) begin
                deadline[i] = -1;
                valid_m[i]  = 1'b0;
            end else if (deadline[i] == edge_n) begin
                deadline[i] = -1;
                valid_m[i]  = 1'b1;
            end
            e.ev[i]   = valid_m[i];
            e.busy[i] = (deadline[i] != -1);
        end
        edge_n++;
        q.push_back(e);
    endtask

    // One clock: drive at the falling edge, record what the next rising edge yields.
    task automatic cycle(input bit bv, input bit clr, input bit rst);
        @(negedge clk);
        board_valid = bv;
        clear_eval  = clr;
        reset       = rst;
        model_step(bv, clr, rst);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Reset raised between edges: outputs must drop before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        board_valid = 1'b0;
        clear_eval  = 1'b0;
        model_step(1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("async_reset eval_valid", i, ev_v[i], 1'b0);
`ifdef LATENCY_SM_BUSY_EN
            check("async_reset busy", i, bz_v[i], 1'b0);
`endif
        end
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every registered output once per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow t=%0t: got empty queue expected one entry", $time);
            end else begin
                e = q.pop_front();
                for (int i = 0; i < NI; i++) begin
                    check("eval_valid", i, ev_v[i], e.ev[i]);
`ifdef LATENCY_SM_BUSY_EN
                    check("busy", i, bz_v[i], e.busy[i]);
`endif
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int r;
        for (int i = 0; i < NI; i++) begin
            deadline[i] = -1;
            valid_m[i]  = 1'b0;
        end
        reset       = 1'b1;
        board_valid = 1'b0;
        clear_eval  = 1'b0;
        model_step(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        idle(2);

        // Single board: L=11 low through edge 10, high after edge 11, held, then cleared.
        cycle(1'b1, 1'b0, 1'b0);
        idle(11);
        check("dir_rise_before_edge11", 0, ev11, 1'b0);
        idle(1);
        check("dir_rise_after_edge11", 0, ev11, 1'b1);
        idle(20);
        cycle(1'b0, 1'b1, 1'b0);
        idle(3);

        // Restart at edge 5: first rise after edge 16.
        cycle(1'b1, 1'b0, 1'b0);
        idle(4);
        cycle(1'b1, 1'b0, 1'b0);
        idle(20);
        cycle(1'b0, 1'b1, 1'b0);
        idle(2);

        // Abort at edge 4, then board+clear together at edge 20.
        cycle(1'b1, 1'b0, 1'b0);
        idle(3);
        cycle(1'b0, 1'b1, 1'b0);
        idle(15);
        cycle(1'b1, 1'b1, 1'b0);
        idle(14);
        cycle(1'b0, 1'b1, 1'b0);
        idle(2);

        // New board while VALID (L=1 dips for one cycle), clear in IDLE.
        cycle(1'b1, 1'b0, 1'b0);
        idle(3);
        cycle(1'b1, 1'b0, 1'b0);
        idle(3);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        idle(2);

        // Async reset mid-COUNT, then a full count after release.
        cycle(1'b1, 1'b0, 1'b0);
        idle(3);
        async_reset();
        cycle(1'b1, 1'b0, 1'b0);
        idle(14);

        // Async reset while VALID, then a full count after release.
        async_reset();
        idle(2);
        cycle(1'b1, 1'b0, 1'b0);
        idle(14);
        cycle(1'b0, 1'b1, 1'b0);
        idle(2);

        // Randomized traffic with occasional overlap and resets.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 999));
            cycle(r < 60, (r >= 40) && (r < 90), r >= 996);
        end
        idle(2);

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/latency_sm.md
LATENCY_SM -- requirements
Module: latency_sm

Interface
REQ-001 The block SHALL have parameter LATENCY_COUNT, default 1, giving the pipeline latency in clk cycles from board_valid to eval_valid; legal range 1..1023.
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port board_valid, input, 1 bit, a single-cycle pulse meaning a new board was presented to the evaluation pipeline.
REQ-005 The block SHALL have port clear_eval, input, 1 bit, meaning the consumer has taken the result or aborts the evaluation.
REQ-006 The block SHALL have port eval_valid, output, 1 bit, high while the evaluation result is valid.
REQ-007 The block SHALL have port busy, output, 1 bit, present only with LATENCY_SM_BUSY_EN (see REQ-018).

Function
REQ-008 The block SHALL implement a three-state FSM with states IDLE, COUNT and VALID, plus a down-counter of width $clog2(LATENCY_COUNT+1).
REQ-009 IDLE behaviour SHALL be: board_valid=1 at a clk edge -> go to COUNT and load the counter with LATENCY_COUNT-1.
REQ-010 COUNT behaviour SHALL be: decrement each edge; at an edge where the counter is 0 -> go to VALID.
  - Result: board_valid sampled at edge k makes eval_valid high immediately after edge k+LATENCY_COUNT.
  - For LATENCY_COUNT=1, eval_valid goes high after edge k+1.
REQ-011 VALID behaviour SHALL be: eval_valid=1 and held indefinitely until clear_eval=1 or board_valid=1 is sampled.
REQ-012 eval_valid SHALL be a registered output, equal to (state==VALID), with no combinational path from any input.
REQ-013 clear_eval=1 without board_valid in COUNT or VALID SHALL force IDLE and reload nothing; eval_valid is low after that edge.
REQ-014 board_valid=1 in COUNT or VALID SHALL restart the count: go to COUNT, reload LATENCY_COUNT-1, and drop eval_valid, so the output always tracks the most recent board.
REQ-015 When board_valid and clear_eval are both 1 at the same edge in any state, board_valid SHALL take priority (restart per REQ-009/REQ-014).
REQ-016 clear_eval in IDLE SHALL have no effect.
  - Any unreachable state encoding returns to IDLE.

Reset
REQ-017 reset=1 SHALL asynchronously force state=IDLE, counter=0, eval_valid=0 (and busy=0 if present) regardless of clk; reset asserted mid-COUNT or in VALID discards the evaluation, and the first board_valid after release starts a full LATENCY_COUNT count.

Configuration
REQ-018 Macro LATENCY_SM_BUSY_EN SHALL control the busy feature.
  - When defined: output busy exists, is registered, and equals (state==COUNT).
  - When undefined: the busy port and its logic are absent, and all other behaviour is identical.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - LATENCY_COUNT=11; board_valid pulse at edge 0 -> eval_valid low through edge 10, high after edge 11, stays high 20 cycles; clear_eval pulse -> low next cycle.
  - LATENCY_COUNT=11; board_valid at edge 0, again at edge 5 -> eval_valid first high after edge 16.
  - LATENCY_COUNT=11; clear_eval at edge 4 after board_valid at edge 0 -> eval_valid never rises; board_valid and clear_eval together at edge 20 -> eval_valid high after edge 31.
  - LATENCY_COUNT=1; board_valid at edge 0 -> eval_valid high after edge 1; board_valid in VALID -> low for exactly 1 cycle, then high.
  - Async reset asserted between edges during COUNT (and during VALID) -> eval_valid/busy drop immediately; after release, board_valid at edge r -> eval_valid after edge r+LATENCY_COUNT.
  - With LATENCY_SM_BUSY_EN, LATENCY_COUNT=4 -> busy high exactly 4 cycles, never overlapping eval_valid.
